// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic types and helpers for the NTT datapath.
// mm_op_t is the operation record carried through the multiplier front end.
package ntt_arith_pkg;

   localparam int unsigned OP_W = 30;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [OP_W-1:0] q;
      logic [OP_W+1:0] mu;
      logic            loaded;
      logic            valid;
   } mm_op_t;

   // floor(2^(2*width) / q); used to prepare table contents, not in the datapath
   function automatic logic [127:0] barrett_mu(input int unsigned width, input logic [127:0] q);
      logic [127:0] num;
      num = 128'd1 << (2 * width);
      return num / q;
   endfunction

endpackage

// File: rtl/barrett_reduce_stage.sv
// Three-stage Barrett reduction of a 2*WIDTH-bit product p modulo q (S3..S5).
// All registers advance together on en_i; unloaded moduli yield c=0 with err set.
module barrett_reduce_stage #(
   parameter int unsigned WIDTH = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [2*WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0]   q_i,
   input  logic [WIDTH+1:0]   mu_i,
   input  logic               loaded_i,
   input  logic               valid_i,
   output logic [WIDTH-1:0]   c_o,
   output logic               err_o,
   output logic               valid_o
);

   localparam int unsigned RW = WIDTH + 2;
   localparam int unsigned TW = 2 * WIDTH + 3;

   logic [RW-1:0]    s3_qhat_d, s3_qhat_q, s3_p_q;
   logic [WIDTH-1:0] s3_mod_q, s4_mod_q;
   logic             s3_ld_q, s3_vld_q, s4_ld_q, s4_vld_q;
   logic [RW-1:0]    s4_r_d, s4_r_q, r1;
   logic [WIDTH-1:0] c_d, c_q;
   logic             err_d, err_q, vld_q;

   // qhat is taken straight from the product so no unused low bits of t are kept
   assign s3_qhat_d = RW'((TW'(p_i[2*WIDTH-1:WIDTH-1]) * TW'(mu_i)) >> (WIDTH + 1));

   // r < 3q < 2^(WIDTH+2), so the low RW bits of p and qhat*q are sufficient
   assign s4_r_d = s3_p_q - s3_qhat_q * RW'(s3_mod_q);

   always_comb begin
      r1    = s4_r_q;
      c_d   = '0;
      err_d = s4_vld_q && !s4_ld_q;
      if (s4_r_q >= RW'(s4_mod_q)) begin
         r1 = s4_r_q - RW'(s4_mod_q);
      end
      if (s4_ld_q) begin
         c_d = (r1 >= RW'(s4_mod_q)) ? WIDTH'(r1 - RW'(s4_mod_q)) : WIDTH'(r1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_qhat_q <= '0;
         s3_p_q    <= '0;
         s3_mod_q  <= '0;
         s3_ld_q   <= 1'b0;
         s3_vld_q  <= 1'b0;
         s4_r_q    <= '0;
         s4_mod_q  <= '0;
         s4_ld_q   <= 1'b0;
         s4_vld_q  <= 1'b0;
         c_q       <= '0;
         err_q     <= 1'b0;
         vld_q     <= 1'b0;
      end else if (en_i) begin
         s3_qhat_q <= s3_qhat_d;
         s3_p_q    <= p_i[RW-1:0];
         s3_mod_q  <= q_i;
         s3_ld_q   <= loaded_i;
         s3_vld_q  <= valid_i;
         s4_r_q    <= s4_r_d;
         s4_mod_q  <= s3_mod_q;
         s4_ld_q   <= s3_ld_q;
         s4_vld_q  <= s3_vld_q;
         c_q       <= c_d;
         err_q     <= err_d;
         vld_q     <= s4_vld_q;
      end
   end

   assign c_o     = c_q;
   assign err_o   = err_q;
   assign valid_o = vld_q;

endmodule

// File: rtl/modular_multiplier_pipe.sv
// Five-stage pipelined Barrett modular multiplier c = a*b mod q with a runtime modulus table.
// A single global advance signal stalls every stage while the output is held.
module modular_multiplier_pipe
   import ntt_arith_pkg::*;
#(
   parameter int unsigned WIDTH      = OP_W,
   parameter int unsigned NUM_MODULI = 16,
   parameter int unsigned IDX_W      = $clog2(NUM_MODULI)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [WIDTH-1:0] cfg_q,
   input  logic [WIDTH+1:0] cfg_mu,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic             out_err
);

   logic adv;

   logic [WIDTH-1:0]      tbl_mod_q [NUM_MODULI];
   logic [WIDTH+1:0]      tbl_mu_q  [NUM_MODULI];
   logic [NUM_MODULI-1:0] tbl_ld_q;

   mm_op_t s1_d, s1_q;

   logic [2*WIDTH-1:0] s2_p_d, s2_p_q;
   logic [WIDTH-1:0]   s2_mod_q;
   logic [WIDTH+1:0]   s2_mu_q;
   logic               s2_ld_q, s2_vld_q;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // The table is read combinationally before this edge's write lands, so a
   // same-cycle write to the selected entry is seen only by later operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_MODULI; i++) begin
            tbl_mod_q[i] <= '0;
            tbl_mu_q[i]  <= '0;
         end
         tbl_ld_q <= '0;
      end else if (cfg_we) begin
         tbl_mod_q[cfg_idx] <= cfg_q;
         tbl_mu_q[cfg_idx]  <= cfg_mu;
         tbl_ld_q[cfg_idx]  <= 1'b1;
      end
   end

   always_comb begin
      s1_d        = '0;
      s1_d.a      = in_a;
      s1_d.b      = in_b;
      s1_d.q      = tbl_mod_q[in_idx];
      s1_d.mu     = tbl_mu_q[in_idx];
      s1_d.loaded = tbl_ld_q[in_idx];
      s1_d.valid  = in_valid;
   end

   assign s2_p_d = (2*WIDTH)'(s1_q.a) * (2*WIDTH)'(s1_q.b);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_p_q   <= '0;
         s2_mod_q <= '0;
         s2_mu_q  <= '0;
         s2_ld_q  <= 1'b0;
         s2_vld_q <= 1'b0;
      end else if (adv) begin
         s1_q     <= s1_d;
         s2_p_q   <= s2_p_d;
         s2_mod_q <= s1_q.q;
         s2_mu_q  <= s1_q.mu;
         s2_ld_q  <= s1_q.loaded;
         s2_vld_q <= s1_q.valid;
      end
   end

   barrett_reduce_stage #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .clk      (clk),
      .rst      (rst),
      .en_i     (adv),
      .p_i      (s2_p_q),
      .q_i      (s2_mod_q),
      .mu_i     (s2_mu_q),
      .loaded_i (s2_ld_q),
      .valid_i  (s2_vld_q),
      .c_o      (out_c),
      .err_o    (out_err),
      .valid_o  (out_valid)
   );

endmodule

// File: tb/tb_modular_multiplier_pipe.sv
// Scoreboard bench for modular_multiplier_pipe: expectations are pushed on acceptance
// and popped when the DUT hands off a result.
module tb_modular_multiplier_pipe;
   import ntt_arith_pkg::*;

   localparam int W  = 30;
   localparam int NM = 16;
   localparam int IW = 4;

   localparam logic [W-1:0] Q0 = 30'd1063321601;
   localparam logic [W-1:0] Q1 = 30'd1000000007;
   localparam logic [W-1:0] Q2 = 30'd805306369;
   localparam logic [W-1:0] Q3 = 30'd1073741789;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [W-1:0]  cfg_q;
   logic [W+1:0]  cfg_mu;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b;
   logic [IW-1:0] in_idx;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_c;
   logic          out_err;

   always #5 clk = ~clk;

   modular_multiplier_pipe #(
      .WIDTH      (W),
      .NUM_MODULI (NM),
      .IDX_W      (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_q     (cfg_q),
      .cfg_mu    (cfg_mu),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_idx    (in_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_err   (out_err)
   );

   typedef struct {
      logic [W:0] exp;
      int         acc;
   } sb_t;

   sb_t          sbq[$];
   logic [W-1:0] mq [NM];
   logic         ml [NM];
   int           n_cmp = 0;
   int           n_mis = 0;
   int           cyc = 0;
   bit           lat_chk = 1'b0;
   bit           last_acc = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [IW-1:0] idx);
      logic [63:0] pa, pb, pm, r;
      if (!ml[idx]) return {1'b1, {W{1'b0}}};
      pa = {34'd0, a};
      pb = {34'd0, b};
      pm = {34'd0, mq[idx]};
      r  = (pa * pb) % pm;
      return {1'b0, r[W-1:0]};
   endfunction

   task automatic settle();
      sb_t e;
      #1;
      last_acc = 1'b0;
      if (!rst) begin
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("result", {33'd0, out_err, out_c}, {33'd0, e.exp});
               if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd5);
            end
         end
         if (in_valid && in_ready) begin
            e.exp = model(in_a, in_b, in_idx);
            e.acc = cyc;
            sbq.push_back(e);
            last_acc = 1'b1;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         sbq.delete();
         for (int i = 0; i < NM; i++) begin
            mq[i] = '0;
            ml[i] = 1'b0;
         end
      end else if (cfg_we) begin
         mq[cfg_idx] = cfg_q;
         ml[cfg_idx] = 1'b1;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic set_cfg(input logic [IW-1:0] idx, input logic [W-1:0] q);
      logic [127:0] m;
      m       = barrett_mu(W, {98'd0, q});
      cfg_we  = 1'b1;
      cfg_idx = idx;
      cfg_q   = q;
      cfg_mu  = m[W+1:0];
   endtask

   task automatic load(input logic [IW-1:0] idx, input logic [W-1:0] q);
      set_cfg(idx, q);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [IW-1:0] idx);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_idx   = idx;
      for (int k = 0; k < 100 && !done; k++) begin
         settle();
         done = last_acc;
         advance();
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 200 && sbq.size() != 0; k++) step();
      chk("drain", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] c0;
      logic [31:0]  tmp;
      logic [IW-1:0] ridx;
      int           nacc;

      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_q = '0; cfg_mu = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_idx = '0; out_ready = 1'b1;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_c", 64'(out_c), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // single op, latency 5
      load(4'd0, Q0);
      lat_chk = 1'b1;
      send(Q0 - 1, Q0 - 1, 4'd0);
      drain();

      // back-to-back stream
      send(Q0 - 1, 30'd2, 4'd0);
      send(30'd90, 30'd30, 4'd0);
      send(30'd56789, 30'd1234789, 4'd0);
      drain();

      // backpressure for 3 cycles mid-stream
      lat_chk = 1'b0;
      for (int i = 0; i < 8; i++) send(30'(1000 + i * 7777), 30'(Q0 - 5 - i), 4'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 30'd123456;
      in_b      = 30'd654321;
      in_idx    = 4'd0;
      c0        = '0;
      for (int j = 0; j < 3; j++) begin
         settle();
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         if (j == 0) c0 = out_c;
         else chk("bp_out_c_hold", 64'(out_c), 64'(c0));
         advance();
      end
      out_ready = 1'b1;
      send(30'd123456, 30'd654321, 4'd0);
      send(30'd42, 30'd42, 4'd0);
      drain();

      // unloaded entry followed by a good op
      lat_chk = 1'b1;
      send(30'd3, 30'd4, 4'd5);
      send(30'd7, 30'd9, 4'd0);
      drain();

      // same-cycle table write uses the old entry
      load(4'd1, Q1);
      set_cfg(4'd1, Q2);
      send(30'd100000, 30'd200000, 4'd1);
      cfg_we = 1'b0;
      send(30'd100000, 30'd200000, 4'd1);
      drain();
      load(4'(NM - 1), Q1);
      set_cfg(4'(NM - 1), Q3);
      send(30'd99999, 30'd888888, 4'(NM - 1));
      cfg_we = 1'b0;
      send(30'd99999, 30'd888888, 4'(NM - 1));
      drain();

      // reset with 4 ops in flight
      for (int i = 0; i < 4; i++) send(30'(500 + i), 30'(700 + i), 4'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         settle();
         chk("rst_flush_valid", 64'(out_valid), 64'd0);
         advance();
      end
      load(4'd0, Q0);
      load(4'd1, Q1);
      load(4'd2, Q2);
      load(4'd3, Q3);
      send(30'd56789, 30'd1234789, 4'd0);
      drain();

      // randomised stream across 4 moduli
      lat_chk = 1'b0;
      nacc = 0;
      for (int k = 0; k < 60000 && nacc < 10000; k++) begin
         ridx      = 4'($urandom_range(0, 3));
         tmp       = $urandom % {2'b00, mq[ridx]};
         in_a      = tmp[W-1:0];
         tmp       = $urandom % {2'b00, mq[ridx]};
         in_b      = tmp[W-1:0];
         in_idx    = ridx;
         in_valid  = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         settle();
         if (last_acc) nacc++;
         advance();
      end
      out_ready = 1'b1;
      chk("random_ops", 64'(nacc), 64'd10000);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
